// File: rtl/ysyx_23060201_lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - RV32 funct3 encodings for loads and stores
//   - FSM state encoding (2 bits)
//   - Size-to-byte-mask constants (4-lane word)
//   - Helpers for request legality and natural-alignment checking
package ysyx_23060201_lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // funct3[1:0] encodes the access size for every legal load/store
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [3:0] MASK_BYTE = 4'h1;
  localparam logic [3:0] MASK_HALF = 4'h3;
  localparam logic [3:0] MASK_WORD = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == SIZE_HALF) && off[0]) || ((size == SIZE_WORD) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/ysyx_23060201_lsu_align.sv
// Purely combinational lane logic for the LSU.
//   size      : access size (funct3[1:0])
//   uns       : zero-extend loads (funct3[2])
//   off       : byte offset within the word (addr[1:0])
//   wdata     : right-aligned store data
//   rdata     : raw word read from memory
//   mask      : 4-lane byte mask for the access
//   wdata_sh  : store data shifted into its lanes
//   rdata_ext : load data extracted and sign/zero extended
// The offset is forced to the natural alignment of the access size, so a
// misaligned access that is allowed to proceed touches the aligned lanes.
module ysyx_23060201_lsu_align
  import ysyx_23060201_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            size,
  input  logic                  uns,
  input  logic [1:0]            off,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [3:0]            mask,
  output logic [DATA_WIDTH-1:0] wdata_sh,
  output logic [DATA_WIDTH-1:0] rdata_ext
);

  function automatic logic [DATA_WIDTH-1:0] ext_byte(input logic [7:0] b, input logic zext);
    logic signed [7:0]            sb;
    logic signed [DATA_WIDTH-1:0] w;
    sb = b;
    w  = {{(DATA_WIDTH-8){sb[7] & ~zext}}, sb};
    return w;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] ext_half(input logic [15:0] h, input logic zext);
    logic signed [15:0]           sh;
    logic signed [DATA_WIDTH-1:0] w;
    sh = h;
    w  = {{(DATA_WIDTH-16){sh[15] & ~zext}}, sh};
    return w;
  endfunction

  logic [1:0]            off_eff;
  logic [DATA_WIDTH-1:0] rdata_sh;

  always_comb begin
    off_eff = 2'b00;
    mask    = MASK_WORD;
    case (size)
      SIZE_BYTE: begin
        off_eff = off;
        mask    = MASK_BYTE << off_eff;
      end
      SIZE_HALF: begin
        off_eff = {off[1], 1'b0};
        mask    = MASK_HALF << off_eff;
      end
      default: begin
        off_eff = 2'b00;
        mask    = MASK_WORD;
      end
    endcase
  end

  assign wdata_sh = wdata << {off_eff, 3'b000};
  assign rdata_sh = rdata >> {off_eff, 3'b000};

  always_comb begin
    rdata_ext = rdata_sh;
    case (size)
      SIZE_BYTE: rdata_ext = ext_byte(rdata_sh[7:0], uns);
      SIZE_HALF: rdata_ext = ext_half(rdata_sh[15:0], uns);
      default:   rdata_ext = rdata_sh;
    endcase
  end

endmodule

// File: rtl/ysyx_23060201_lsu.sv
// Load/store unit: initiator side of the data-memory port.
// Takes one request at a time from EXU (req_*), performs a single-cycle
// memory access (mem_*), and returns extended load data to WBU (resp_*).
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_ready   : EXU handshake; req_is_store, req_funct3,
//                           req_addr, req_wdata describe the access
//   resp_valid/resp_ready : WBU handshake; resp_rdata, resp_err
//   mem_ren/raddr/rmask   : read port, mem_rdata returns combinationally
//   mem_wen/waddr/wmask/wdata : write port, commits on posedge clk
// Build option: define YSYX_23060201_LSU_MISALIGN_CHECK_EN to report
// misaligned half/word accesses as errors instead of aligning them down.
module ysyx_23060201_lsu
  import ysyx_23060201_lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic [7:0]            mem_rmask,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [7:0]            mem_wmask,
  output logic [DATA_WIDTH-1:0] mem_wdata
);

  lsu_state_e            state_q, state_d;
  logic                  rdy_q;
  logic                  accept;
  logic                  req_err;

  logic                  is_store_q;
  logic [2:0]            f3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [3:0]            mask;
  logic [DATA_WIDTH-1:0] wdata_sh;
  logic [DATA_WIDTH-1:0] rdata_ext;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic                  in_access;

`ifdef YSYX_23060201_LSU_MISALIGN_CHECK_EN
  assign req_err = !f3_legal(req_is_store, req_funct3) ||
                   misaligned(req_funct3[1:0], req_addr[1:0]);
`else
  assign req_err = !f3_legal(req_is_store, req_funct3);
`endif

  // rdy_q holds req_ready low until the first edge after reset release
  assign req_ready = (state_q == ST_IDLE) && rdy_q;
  assign accept    = req_valid && req_ready;

  // Control: FSM state and ready gate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = req_err ? ST_RESP : ST_ACCESS;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   if (resp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Request latch (IDLE -> ACCESS/RESP); outputs are gated by state, so no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      is_store_q <= req_is_store;
      f3_q       <= req_funct3;
      addr_q     <= req_addr;
      wdata_q    <= req_wdata;
      err_q      <= req_err;
    end
  end

  ysyx_23060201_lsu_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_align (
    .size      (f3_q[1:0]),
    .uns       (f3_q[2]),
    .off       (addr_q[1:0]),
    .wdata     (wdata_q),
    .rdata     (mem_rdata),
    .mask      (mask),
    .wdata_sh  (wdata_sh),
    .rdata_ext (rdata_ext)
  );

  // Access stage (ACCESS -> RESP): capture extracted load data
  always_ff @(posedge clk) begin
    if (in_access && !is_store_q) rdata_q <= rdata_ext;
  end

  assign in_access = (state_q == ST_ACCESS);
  assign word_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};

  assign mem_ren   = in_access && !is_store_q;
  assign mem_wen   = in_access && is_store_q;
  assign mem_raddr = mem_ren ? word_addr : '0;
  assign mem_rmask = mem_ren ? {4'b0000, mask} : 8'h00;
  assign mem_waddr = mem_wen ? word_addr : '0;
  assign mem_wmask = mem_wen ? {4'b0000, mask} : 8'h00;
  assign mem_wdata = mem_wen ? wdata_sh : '0;

  // Response stage: held stable until the WBU handshake
  assign resp_valid = (state_q == ST_RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = (resp_valid && !err_q && !is_store_q) ? rdata_q : '0;

endmodule

// File: tb/tb_ysyx_23060201_lsu.sv
module tb_ysyx_23060201_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_ren;
  logic [31:0] mem_raddr;
  logic [7:0]  mem_rmask;
  logic [31:0] mem_rdata;
  logic        mem_wen;
  logic [31:0] mem_waddr;
  logic [7:0]  mem_wmask;
  logic [31:0] mem_wdata;

  int n_chk = 0;
  int n_err = 0;

  logic        mem_init;
  logic [31:0] mem [0:15];

  always #5 clk = ~clk;

  ysyx_23060201_lsu #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_is_store (req_is_store),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_ren      (mem_ren),
    .mem_raddr    (mem_raddr),
    .mem_rmask    (mem_rmask),
    .mem_rdata    (mem_rdata),
    .mem_wen      (mem_wen),
    .mem_waddr    (mem_waddr),
    .mem_wmask    (mem_wmask),
    .mem_wdata    (mem_wdata)
  );

  // Memory model: 16 words, combinational read, masked write at posedge
  assign mem_rdata = mem_ren ? mem[mem_raddr[5:2]] : 32'h0;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[0] <= 32'h8001_1234;
    end else if (mem_wen) begin
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) mem[mem_waddr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", tag, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    int n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("ready_timeout", 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_is_store = st;
    req_funct3   = f3;
    req_addr     = a;
    req_wdata    = wd;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Load: ACCESS cycle check, then RESP check, then back to IDLE
  task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                      input logic [7:0] rmask, input logic [31:0] exp);
    issue(1'b0, f3, a, 32'h0);
    chk({tag, "_ren"}, 32'(mem_ren), 32'd1);
    chk({tag, "_raddr"}, mem_raddr, {a[31:2], 2'b00});
    chk({tag, "_rmask"}, 32'(mem_rmask), 32'(rmask));
    @(negedge clk);
    chk({tag, "_vld"}, 32'(resp_valid), 32'd1);
    chk({tag, "_rdata"}, resp_rdata, exp);
    chk({tag, "_err"}, 32'(resp_err), 32'd0);
    @(negedge clk);
  endtask

  // Illegal/misaligned request: RESP directly, no memory access
  task automatic err_req(input string tag, input logic st, input logic [2:0] f3,
                         input logic [31:0] a);
    issue(st, f3, a, 32'h1234_5678);
    chk({tag, "_noacc"}, 32'(mem_ren | mem_wen), 32'd0);
    chk({tag, "_vld"}, 32'(resp_valid), 32'd1);
    chk({tag, "_err"}, 32'(resp_err), 32'd1);
    chk({tag, "_rdata"}, resp_rdata, 32'h0);
    @(negedge clk);
  endtask

  initial begin
    rst_n        = 1'b0;
    mem_init     = 1'b1;
    req_valid    = 1'b0;
    req_is_store = 1'b0;
    req_funct3   = 3'b000;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    resp_ready   = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_outs", 32'({resp_valid, resp_err, mem_ren, mem_wen}), 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    mem_init = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    chk("rel_ready", 32'(req_ready), 32'd1);

    // SW aligned word
    issue(1'b1, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF);
    chk("sw_wen", 32'(mem_wen), 32'd1);
    chk("sw_ren", 32'(mem_ren), 32'd0);
    chk("sw_waddr", mem_waddr, 32'h8000_0004);
    chk("sw_wmask", 32'(mem_wmask), 32'h0F);
    chk("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("sw_novld", 32'(resp_valid), 32'd0);
    @(negedge clk);
    chk("sw_vld", 32'(resp_valid), 32'd1);
    chk("sw_err", 32'(resp_err), 32'd0);
    chk("sw_rdata", resp_rdata, 32'h0);
    chk("sw_busy", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("sw_idle", 32'(req_ready), 32'd1);
    chk("sw_mem", mem[1], 32'hDEAD_BEEF);

    // Halfword loads from upper half of 0x80011234
    load("lh", 3'b001, 32'h8000_0002, 8'h0C, 32'hFFFF_8001);
    load("lhu", 3'b101, 32'h8000_0002, 8'h0C, 32'h0000_8001);

    // SB to top lane, then byte loads back
    issue(1'b1, 3'b000, 32'h8000_0003, 32'h0000_00AB);
    chk("sb_wmask", 32'(mem_wmask), 32'h08);
    chk("sb_wdata", 32'(mem_wdata[31:24]), 32'hAB);
    repeat (2) @(negedge clk);
    chk("sb_mem", mem[0], 32'hAB01_1234);
    load("lbu", 3'b100, 32'h8000_0003, 8'h08, 32'h0000_00AB);
    load("lb", 3'b000, 32'h8000_0003, 8'h08, 32'hFFFF_FFAB);
    load("lb1", 3'b000, 32'h8000_0001, 8'h02, 32'h0000_0012);

    // Misaligned word load
`ifdef YSYX_23060201_LSU_MISALIGN_CHECK_EN
    err_req("lw_mis", 1'b0, 3'b010, 32'h8000_0001);
`else
    load("lw_mis", 3'b010, 32'h8000_0001, 8'h0F, 32'hAB01_1234);
`endif

    // Illegal funct3
    err_req("ld011", 1'b0, 3'b011, 32'h8000_0000);
    err_req("st100", 1'b1, 3'b100, 32'h8000_0004);
    chk("st100_mem", mem[1], 32'hDEAD_BEEF);

    // Backpressure: response held, new request ignored
    resp_ready = 1'b0;
    issue(1'b0, 3'b010, 32'h8000_0004, 32'h0);
    @(negedge clk);
    req_valid    = 1'b1;
    req_is_store = 1'b1;
    req_funct3   = 3'b010;
    req_addr     = 32'h8000_0004;
    req_wdata    = 32'h1111_1111;
    for (int i = 0; i < 5; i++) begin
      chk("bp_vld", 32'(resp_valid), 32'd1);
      chk("bp_rdata", resp_rdata, 32'hDEAD_BEEF);
      chk("bp_busy", 32'(req_ready | mem_wen), 32'd0);
      @(negedge clk);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle", 32'(req_ready), 32'd1);
    chk("bp_novld", 32'(resp_valid), 32'd0);
    chk("bp_mem", mem[1], 32'hDEAD_BEEF);

    // Reset dropped during a store ACCESS cycle, before its posedge
    issue(1'b1, 3'b010, 32'h8000_0008, 32'hCAFE_F00D);
    chk("ra_wen", 32'(mem_wen), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ra_wen0", 32'(mem_wen), 32'd0);
    chk("ra_outs", 32'({req_ready, resp_valid, resp_err, mem_ren}), 32'd0);
    chk("ra_waddr", mem_waddr, 32'h0);
    chk("ra_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("ra_mem", mem[2], 32'h0);
    @(negedge clk);
    chk("ra_ready", 32'(req_ready), 32'd1);
    load("post_lw", 3'b010, 32'h8000_0008, 8'h0F, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
